// File: rtl/hc153_tdm_demux_pkg.sv
// hc153_tdm_demux_pkg
//   Shared definitions for the TDM receive demultiplexer.
//   SLOT_BITS / NUM_SLOTS : frame geometry (4 slots, 2-bit select)
//   slot_t                : slot index type
//   slot_slice()          : bit offset of slot k within a parallel frame word
package hc153_tdm_demux_pkg;

   localparam int unsigned SLOT_BITS = 2;
   localparam int unsigned NUM_SLOTS = 4;

   typedef logic [SLOT_BITS-1:0] slot_t;

   function automatic int unsigned slot_slice(input slot_t k, input int unsigned width);
      return 32'(k) * width;
   endfunction

endpackage

// File: rtl/hc153_tdm_demux_if.sv
// hc153_tdm_demux_if
//   Bus between the far-end mux pair / control source and the demultiplexer.
//   Inputs to the demux : CEN, SYNCN, E1N, E2N, D1, D2
//   Outputs of the demux: S1, S2 (select back to the mux), Q1, Q2, FRM, SLIP
//   master modport drives the inputs, slave modport is the demux side.
interface hc153_tdm_demux_if #(
   parameter int unsigned WIDTH = 1
);
   logic                 CEN;
   logic                 SYNCN;
   logic                 E1N;
   logic                 E2N;
   logic [WIDTH-1:0]     D1;
   logic [WIDTH-1:0]     D2;
   logic                 S1;
   logic                 S2;
   logic [4*WIDTH-1:0]   Q1;
   logic [4*WIDTH-1:0]   Q2;
   logic                 FRM;
   logic                 SLIP;

   modport master (
      output CEN, SYNCN, E1N, E2N, D1, D2,
      input  S1, S2, Q1, Q2, FRM, SLIP
   );

   modport slave (
      input  CEN, SYNCN, E1N, E2N, D1, D2,
      output S1, S2, Q1, Q2, FRM, SLIP
   );
endinterface

// File: rtl/hc153_tdm_demux_chan.sv
// hc153_tdm_chan
//   One receive channel: per-slot shadow register plus parallel frame register.
//   clk_i, rstn_i : clock, synchronous active-low reset
//   slot_i        : slot being sampled this cycle
//   cap_i         : sample d_i into shadow[slot_i]
//   done_i        : frame completes; load q_o from shadow plus live slot-3 data
//   en_n_i        : active-low channel enable (disabled samples are zero)
//   d_i           : serial line data
//   q_o           : reassembled frame, slot k at bits k*WIDTH +: WIDTH
module hc153_tdm_chan
   import hc153_tdm_demux_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  slot_t              slot_i,
   input  logic               cap_i,
   input  logic               done_i,
   input  logic               en_n_i,
   input  logic [WIDTH-1:0]   d_i,
   output logic [4*WIDTH-1:0] q_o
);

   logic [WIDTH-1:0]   dval;
   logic [4*WIDTH-1:0] sh_q, sh_d;
   logic [4*WIDTH-1:0] q_q, q_d;

   always_comb begin
      dval = en_n_i ? '0 : d_i;
      sh_d = sh_q;
      q_d  = q_q;
      if (cap_i) begin
         for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (slot_i == slot_t'(k)) begin
               sh_d[slot_slice(slot_t'(k), WIDTH) +: WIDTH] = dval;
            end
         end
      end
      // slot-3 sample goes straight into the frame word, bypassing the shadow
      if (done_i) begin
         q_d = {dval, sh_q[3*WIDTH-1:0]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sh_q <= '0;
         q_q  <= '0;
      end else begin
         sh_q <= sh_d;
         q_q  <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/hc153_tdm_demux.sv
// hc153_tdm_demux
//   TDM receiver for a dual 4-input mux transmitter. Owns the slot counter,
//   drives the select back ({S1,S2} = slot), samples D1/D2 once per slot and
//   presents complete frames on Q1/Q2 with a one-cycle FRM strobe.
//   CLK  : clock, all state on rising edge
//   RSTN : synchronous active-low reset
//   bus  : slave side of hc153_tdm_demux_if (CEN, SYNCN, E1N, E2N, D1, D2 in;
//          S1, S2, Q1, Q2, FRM, SLIP out)
module hc153_tdm_demux
   import hc153_tdm_demux_pkg::*;
#(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned SLOTS = 4
) (
   input  logic              CLK,
   input  logic              RSTN,
   hc153_tdm_demux_if.slave  bus
);

   if (SLOTS != NUM_SLOTS) begin : g_bad_slots
      $error("hc153_tdm_demux: SLOTS must be 4");
   end

   slot_t slot_q, slot_d;
   slot_t cap_slot;
   logic  frm_q, frm_d;
   logic  slip_q, slip_d;
   logic  active, sync, done;

   always_comb begin
      active   = !bus.CEN;
      sync     = active && !bus.SYNCN;
      // a sync cycle is sampled as slot 0 whatever the counter says
      cap_slot = sync ? '0 : slot_q;
      done     = active && bus.SYNCN && (slot_q == slot_t'(NUM_SLOTS - 1));
      frm_d    = done;
      slip_d   = sync && (slot_q != '0);
      if (!active) begin
         slot_d = slot_q;
      end else if (sync) begin
         slot_d = slot_t'(1);
      end else begin
         slot_d = slot_q + slot_t'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         slot_q <= '0;
         frm_q  <= 1'b0;
         slip_q <= 1'b0;
      end else begin
         slot_q <= slot_d;
         frm_q  <= frm_d;
         slip_q <= slip_d;
      end
   end

   hc153_tdm_chan #(.WIDTH(WIDTH)) u_chan1 (
      .clk_i  (CLK),
      .rstn_i (RSTN),
      .slot_i (cap_slot),
      .cap_i  (active),
      .done_i (done),
      .en_n_i (bus.E1N),
      .d_i    (bus.D1),
      .q_o    (bus.Q1)
   );

   hc153_tdm_chan #(.WIDTH(WIDTH)) u_chan2 (
      .clk_i  (CLK),
      .rstn_i (RSTN),
      .slot_i (cap_slot),
      .cap_i  (active),
      .done_i (done),
      .en_n_i (bus.E2N),
      .d_i    (bus.D2),
      .q_o    (bus.Q2)
   );

   assign bus.S1   = slot_q[1];
   assign bus.S2   = slot_q[0];
   assign bus.FRM  = frm_q;
   assign bus.SLIP = slip_q;

endmodule

// File: tb/tb_hc153_tdm_demux.sv
// tb_hc153_tdm_demux
//   Table-driven check of a WIDTH=1 instance plus a back-to-back frame
//   sequence on a WIDTH=4 instance.
module tb_hc153_tdm_demux;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   hc153_tdm_demux_if #(.WIDTH(1)) bus1 ();
   hc153_tdm_demux_if #(.WIDTH(4)) bus4 ();

   hc153_tdm_demux #(.WIDTH(1), .SLOTS(4)) dut1 (
      .CLK  (clk),
      .RSTN (rstn),
      .bus  (bus1)
   );

   hc153_tdm_demux #(.WIDTH(4), .SLOTS(4)) dut4 (
      .CLK  (clk),
      .RSTN (rstn),
      .bus  (bus4)
   );

   typedef struct {
      logic       rstn, cen, syncn, e1n, e2n, d1, d2;
      logic [1:0] s;
      logic       frm, slip;
      logic [3:0] q1, q2;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input int rs, input int ce, input int sy, input int e1,
                              input int e2, input int d1, input int d2, input int s,
                              input int frm, input int slip, input int q1, input int q2);
      vec_t r;
      r.rstn = 1'(rs);  r.cen = 1'(ce);  r.syncn = 1'(sy);
      r.e1n  = 1'(e1);  r.e2n = 1'(e2);  r.d1 = 1'(d1);  r.d2 = 1'(d2);
      r.s    = 2'(s);   r.frm = 1'(frm); r.slip = 1'(slip);
      r.q1   = 4'(q1);  r.q2  = 4'(q2);
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] d1w [4];
   logic [3:0] d2w [4];

   initial begin
      // rs ce sy e1 e2 d1 d2 | s frm slip q1 q2
      // reset
      tbl.push_back(v(0,1,1,0,0,0,0, 0,0,0, 4'h0,4'h0));
      tbl.push_back(v(0,1,1,0,0,0,0, 0,0,0, 4'h0,4'h0));
      // basic frame: D1=1,0,1,1  D2=0,1,1,0
      tbl.push_back(v(1,0,1,0,0,1,0, 1,0,0, 4'h0,4'h0));
      tbl.push_back(v(1,0,1,0,0,0,1, 2,0,0, 4'h0,4'h0));
      tbl.push_back(v(1,0,1,0,0,1,1, 3,0,0, 4'h0,4'h0));
      tbl.push_back(v(1,0,1,0,0,1,0, 0,1,0, 4'hD,4'h6));
      tbl.push_back(v(1,1,1,0,0,0,0, 0,0,0, 4'hD,4'h6));
      // E2N high in slot 2 only, D2 all ones
      tbl.push_back(v(1,0,1,0,0,1,1, 1,0,0, 4'hD,4'h6));
      tbl.push_back(v(1,0,1,0,0,0,1, 2,0,0, 4'hD,4'h6));
      tbl.push_back(v(1,0,1,0,1,1,1, 3,0,0, 4'hD,4'h6));
      tbl.push_back(v(1,0,1,0,0,1,1, 0,1,0, 4'hD,4'hB));
      // CEN hold for 3 cycles at slot 2 (SYNCN low ignored while held)
      tbl.push_back(v(1,0,1,0,0,0,1, 1,0,0, 4'hD,4'hB));
      tbl.push_back(v(1,0,1,0,0,1,0, 2,0,0, 4'hD,4'hB));
      tbl.push_back(v(1,1,0,0,0,1,1, 2,0,0, 4'hD,4'hB));
      tbl.push_back(v(1,1,0,0,0,1,1, 2,0,0, 4'hD,4'hB));
      tbl.push_back(v(1,1,0,0,0,1,1, 2,0,0, 4'hD,4'hB));
      tbl.push_back(v(1,0,1,0,0,1,1, 3,0,0, 4'hD,4'hB));
      tbl.push_back(v(1,0,1,0,0,0,0, 0,1,0, 4'h6,4'h5));
      // SYNCN at slot 2: slip, slot jumps to 1
      tbl.push_back(v(1,0,1,0,0,1,1, 1,0,0, 4'h6,4'h5));
      tbl.push_back(v(1,0,1,0,0,1,1, 2,0,0, 4'h6,4'h5));
      tbl.push_back(v(1,0,0,0,0,1,0, 1,0,1, 4'h6,4'h5));
      tbl.push_back(v(1,0,1,0,0,0,1, 2,0,0, 4'h6,4'h5));
      tbl.push_back(v(1,0,1,0,0,0,1, 3,0,0, 4'h6,4'h5));
      tbl.push_back(v(1,0,1,0,0,1,0, 0,1,0, 4'h9,4'h6));
      // SYNCN at slot 0 (no slip), E1N in slot 1, SYNCN at slot 3 (slip, no FRM)
      tbl.push_back(v(1,0,0,0,0,1,0, 1,0,0, 4'h9,4'h6));
      tbl.push_back(v(1,0,1,1,0,1,0, 2,0,0, 4'h9,4'h6));
      tbl.push_back(v(1,0,1,0,0,0,1, 3,0,0, 4'h9,4'h6));
      tbl.push_back(v(1,0,0,0,0,1,1, 1,0,1, 4'h9,4'h6));
      tbl.push_back(v(1,0,1,0,0,0,0, 2,0,0, 4'h9,4'h6));
      tbl.push_back(v(1,0,1,0,0,1,0, 3,0,0, 4'h9,4'h6));
      tbl.push_back(v(1,0,1,0,0,0,1, 0,1,0, 4'h5,4'h9));
      // reset on the would-be completion edge
      tbl.push_back(v(1,0,1,0,0,1,1, 1,0,0, 4'h5,4'h9));
      tbl.push_back(v(1,0,1,0,0,1,1, 2,0,0, 4'h5,4'h9));
      tbl.push_back(v(1,0,1,0,0,1,1, 3,0,0, 4'h5,4'h9));
      tbl.push_back(v(0,0,1,0,0,1,1, 0,0,0, 4'h0,4'h0));
      tbl.push_back(v(1,1,1,0,0,1,1, 0,0,0, 4'h0,4'h0));

      bus4.CEN = 1'b1; bus4.SYNCN = 1'b1; bus4.E1N = 1'b0; bus4.E2N = 1'b0;
      bus4.D1 = '0; bus4.D2 = '0;

      foreach (tbl[i]) begin
         rstn      = tbl[i].rstn;
         bus1.CEN  = tbl[i].cen;  bus1.SYNCN = tbl[i].syncn;
         bus1.E1N  = tbl[i].e1n;  bus1.E2N   = tbl[i].e2n;
         bus1.D1   = tbl[i].d1;   bus1.D2    = tbl[i].d2;
         step();
         chk($sformatf("row%0d S", i),    int'({bus1.S1, bus1.S2}), int'(tbl[i].s));
         chk($sformatf("row%0d FRM", i),  int'(bus1.FRM),  int'(tbl[i].frm));
         chk($sformatf("row%0d SLIP", i), int'(bus1.SLIP), int'(tbl[i].slip));
         chk($sformatf("row%0d Q1", i),   int'(bus1.Q1),   int'(tbl[i].q1));
         chk($sformatf("row%0d Q2", i),   int'(bus1.Q2),   int'(tbl[i].q2));
      end

      // WIDTH=4 back-to-back frames, counter sits at slot 0 after the reset above
      bus1.CEN = 1'b1;
      rstn     = 1'b1;
      d1w[0] = 4'hA; d1w[1] = 4'h5; d1w[2] = 4'hF; d1w[3] = 4'h0;
      d2w[0] = 4'h3; d2w[1] = 4'hC; d2w[2] = 4'h9; d2w[3] = 4'h6;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 4; k++) begin
            bus4.CEN = 1'b0;
            bus4.D1  = d1w[k];
            bus4.D2  = d2w[k];
            step();
            chk($sformatf("w4 f%0d k%0d S", f, k), int'({bus4.S1, bus4.S2}), (k + 1) % 4);
            chk($sformatf("w4 f%0d k%0d FRM", f, k), int'(bus4.FRM), (k == 3) ? 1 : 0);
            chk($sformatf("w4 f%0d k%0d Q1", f, k), int'(bus4.Q1),
                (f == 0 && k < 3) ? 0 : 32'h0F5A);
            chk($sformatf("w4 f%0d k%0d Q2", f, k), int'(bus4.Q2),
                (f == 0 && k < 3) ? 0 : 32'h69C3);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hc153_tdm_demux.md
Name: hc153_tdm_demux

Overview:
- Receive-side partner of the dual 4-input multiplexer used as a time-division transmitter.
- Owns the slot counter and drives the select lines S1,S2 ({S1,S2} = slot) back to the far-end multiplexer.
- Samples the two muxed serial lines D1/D2 once per slot and reassembles each 4-slot frame into parallel words Q1/Q2.
- Raises a one-cycle frame strobe when a frame completes. Sits between the mux pair and downstream parallel logic.

Parameters:
- WIDTH, 1, bits carried per slot on each line.
- SLOTS, 4, slots per frame; fixed at 4 (2-bit select); any other value is a synthesis-time error.

Ports:
- CLK  input  1  single clock, all state on rising edge.
- RSTN  input  1  synchronous active-low reset.
- CEN  input  1  active-low slot advance; when 1, the block holds all state.
- SYNCN  input  1  active-low frame sync; marks the current cycle as slot 0.
- E1N  input  1  active-low enable, channel 1.
- E2N  input  1  active-low enable, channel 2.
- D1  input  WIDTH  serial line 1, muxed slot data.
- D2  input  WIDTH  serial line 2, muxed slot data.
- S1  output  1  select MSB (slot[1]), registered.
- S2  output  1  select LSB (slot[0]), registered.
- Q1  output  4*WIDTH  channel 1 frame; slice k (bits k*WIDTH +: WIDTH) = slot k.
- Q2  output  4*WIDTH  channel 2 frame, same layout.
- FRM  output  1  one-cycle pulse: Q1/Q2 updated this cycle.
- SLIP  output  1  one-cycle pulse: SYNCN seen while slot != 0.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low (RSTN).
- Reset state: RSTN=0 at an edge clears slot, both shadow registers, Q1, Q2, FRM and SLIP to 0.
  - S1=S2=0 after reset.
  - Reset mid-frame discards the partial frame with no FRM.
- Active cycle (CEN=0, SYNCN=1):
  - shadowN[slot] <= DN if ENN=0, else 0. A disabled channel writes zeros, matching the transmitter's forced-0 output.
  - slot <= slot+1 mod 4; S1/S2 follow slot.
- Frame completion: on an active edge with slot==3:
  - Q1 <= {D1 or 0, sh1[2], sh1[1], sh1[0]}. Slot-3 data bypasses the shadow register.
  - Q2 is loaded the same way.
  - FRM <= 1 for exactly one cycle.
  - Latency: Q is valid the cycle after the slot-3 sample; the shadow slot-3 entry is don't-care.
- Sync (CEN=0, SYNCN=0):
  - The cycle is treated as slot 0: sample into shadow[0], slot <= 1.
  - If the current slot was != 0, SLIP <= 1 for one cycle, the partial frame is dropped, and there is no FRM.
  - SYNCN at slot 0 is a no-op beyond normal capture.
  - SYNCN at slot 3 suppresses FRM; the frame restarts.
- Hold (CEN=1): slot, shadows and Q are held; SYNCN is ignored; FRM and SLIP deassert to 0.
- Enable changes mid-frame take effect per slot, not per frame.
- Q1/Q2 change only on FRM edges or reset; they are stable between strobes.
- FRM and SLIP are never both 1 in the same cycle.

Decomposition:
- Shared package holds:
  - SLOT_BITS=2 and NUM_SLOTS=4.
  - slot_t (2-bit) typedef.
  - Helper function slot_slice(k) giving the bit offset k*WIDTH.
- One sub-module, hc153_tdm_chan, instantiated twice (channel 1, channel 2):
  - Inputs: slot, capture, frame-done, enable, D.
  - Contents: shadow register plus Q register.
- Top level keeps the slot counter, sync/slip logic, FRM and SLIP.

Test Plan:
- Reset then 4 active cycles, E1N=E2N=0, WIDTH=1, D1=1,0,1,1 and D2=0,1,1,0 per slot -> S sequence {S1,S2} = 00,01,10,11. FRM high in cycle 5 only; Q1=4'b1101, Q2=4'b0110.
- E2N=1 for slot 2 only, D2=1 all slots -> Q2=4'b1011. Q1 is unaffected.
- CEN=1 for 3 cycles at slot 2 -> S holds at 10, no FRM; frame completes 3 cycles late with correct data.
- SYNCN=0 at slot 2 -> SLIP pulses one cycle, slot jumps to 1, no FRM for the broken frame. The next FRM appears after 3 more active cycles, with Q reflecting the sync-cycle data in slot 0.
- RSTN=0 at slot 3 (same edge as would-be completion) -> Q stays at its prior reset value 0, FRM=0, S=00.
- Back-to-back frames with WIDTH=4 and slots 0xA,0x5,0xF,0x0 on line 1 -> FRM every 4th cycle, Q1=16'h0F5A each frame.
